// File: rtl/wb_port_arbiter.sv
// Two-requester register-file writeback arbiter: per-port FIFOs, round-robin
// grant, registered write port, and a scoreboard of in-flight destinations.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   alu_valid/ready/rd/data   ALU writeback request channel
//   lsu_valid/ready/rd/data   load writeback request channel
//   we3, ad3, wd3             registered register-file write port
//   pending                   bit i set while a write to x_i is queued or in flight
//   busy                      any queue entry or output stage valid
module wb_port_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [4:0]        lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              we3,
  output logic [4:0]        ad3,
  output logic [DATA_W-1:0] wd3,
  output logic [31:0]       pending,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [AW:0]   C_ONE = (AW+1)'(1);
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);

  // Index 0 is the ALU port, index 1 the LSU port.
  logic [4:0]        rd_mem  [2][DEPTH];
  logic [DATA_W-1:0] dat_mem [2][DEPTH];
  logic [AW-1:0]     wptr [2];
  logic [AW-1:0]     rptr [2];
  logic [AW:0]       cnt  [2];

  logic [4:0]        in_rd  [2];
  logic [DATA_W-1:0] in_dat [2];
  logic [4:0]        hd_rd  [2];
  logic [DATA_W-1:0] hd_dat [2];

  logic [1:0] vld, rdy, full, ne, push, gnt;
  logic       last_lsu;

  always_comb begin
    in_rd[0]  = alu_rd;
    in_rd[1]  = lsu_rd;
    in_dat[0] = alu_data;
    in_dat[1] = lsu_data;
    vld       = {lsu_valid, alu_valid};
    for (int q = 0; q < 2; q++) begin
      full[q]   = (cnt[q] == C_FULL);
      ne[q]     = (cnt[q] != '0);
      hd_rd[q]  = rd_mem[q][rptr[q]];
      hd_dat[q] = dat_mem[q][rptr[q]];
    end
  end

  // Ready depends only on stored occupancy; held low while reset is applied.
  assign rdy       = ~full & {2{~rst}};
  assign alu_ready = rdy[0];
  assign lsu_ready = rdy[1];

  // Writes to x0 complete the handshake but never enter a queue.
  always_comb begin
    for (int q = 0; q < 2; q++)
      push[q] = vld[q] & rdy[q] & (in_rd[q] != 5'd0);
  end

  // On a tie, serve the port that did not win last.
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      ne[0] && ne[1]:  gnt = last_lsu ? 2'b01 : 2'b10;
      ne[0] && !ne[1]: gnt = 2'b01;
      !ne[0] && ne[1]: gnt = 2'b10;
      default:         gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int q = 0; q < 2; q++) begin
        wptr[q] <= '0;
        rptr[q] <= '0;
        cnt[q]  <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          rd_mem[q][i]  <= '0;
          dat_mem[q][i] <= '0;
        end
      end
    end else begin
      for (int q = 0; q < 2; q++) begin
        if (push[q]) begin
          rd_mem[q][wptr[q]]  <= in_rd[q];
          dat_mem[q][wptr[q]] <= in_dat[q];
          wptr[q]             <= wptr[q] + P_ONE;
        end
        if (gnt[q])
          rptr[q] <= rptr[q] + P_ONE;
        case ({push[q], gnt[q]})
          2'b10:   cnt[q] <= cnt[q] + C_ONE;
          2'b01:   cnt[q] <= cnt[q] - C_ONE;
          default: cnt[q] <= cnt[q];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we3      <= 1'b0;
      ad3      <= '0;
      wd3      <= '0;
      last_lsu <= 1'b1;
    end else begin
      we3 <= |gnt;
      if (gnt[0]) begin
        ad3 <= hd_rd[0];
        wd3 <= hd_dat[0];
      end else if (gnt[1]) begin
        ad3 <= hd_rd[1];
        wd3 <= hd_dat[1];
      end
      if (|gnt)
        last_lsu <= gnt[1];
    end
  end

  // Live entries are those within cnt slots of the read pointer.
  always_comb begin
    logic [AW-1:0] off;
    pending = '0;
    off     = '0;
    for (int q = 0; q < 2; q++) begin
      for (int i = 0; i < DEPTH; i++) begin
        off = AW'(i) - rptr[q];
        if ({1'b0, off} < cnt[q])
          pending = pending | (32'd1 << rd_mem[q][i]);
      end
    end
    if (we3)
      pending = pending | (32'd1 << ad3);
  end

  assign busy = (|ne) | we3;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, lsu_valid;
  logic              alu_ready, lsu_ready;
  logic [4:0]        alu_rd, lsu_rd;
  logic [DATA_W-1:0] alu_data, lsu_data;
  logic              we3;
  logic [4:0]        ad3;
  logic [DATA_W-1:0] wd3;
  logic [31:0]       pending;
  logic              busy;

  wb_port_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .we3(we3), .ad3(ad3), .wd3(wd3),
    .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        aq[$];
  ent_t        lq[$];
  logic        m_we;
  logic [4:0]  m_ad;
  logic [31:0] m_wd;
  logic        m_alu_turn;
  logic        in_rst;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    aq.delete();
    lq.delete();
    m_we       = 1'b0;
    m_ad       = '0;
    m_wd       = '0;
    m_alu_turn = 1'b1;
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] p = '0;
    foreach (aq[i]) p[aq[i].rd] = 1'b1;
    foreach (lq[i]) p[lq[i].rd] = 1'b1;
    if (m_we) p[m_ad] = 1'b1;
    return p;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".alu_ready"}, 32'(alu_ready),
        32'(!in_rst && aq.size() < DEPTH));
    chk({tag, ".lsu_ready"}, 32'(lsu_ready),
        32'(!in_rst && lq.size() < DEPTH));
    chk({tag, ".pending"}, pending, m_pending());
    chk({tag, ".busy"}, 32'(busy),
        32'(aq.size() != 0 || lq.size() != 0 || m_we));
    chk({tag, ".we3"}, 32'(we3), 32'(m_we));
    chk({tag, ".ad3"}, 32'(ad3), 32'(m_ad));
    chk({tag, ".wd3"}, wd3, m_wd);
  endtask

  // One clock edge of the reference: pick a winner, retire it, then enqueue.
  function automatic void model_edge(
    input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    bit   a_ok = av && aq.size() < DEPTH;
    bit   l_ok = lv && lq.size() < DEPTH;
    ent_t e;
    if (aq.size() > 0 && (lq.size() == 0 || m_alu_turn)) begin
      e = aq.pop_front();
      m_we = 1'b1; m_ad = e.rd; m_wd = e.d;
      m_alu_turn = 1'b0;
    end else if (lq.size() > 0) begin
      e = lq.pop_front();
      m_we = 1'b1; m_ad = e.rd; m_wd = e.d;
      m_alu_turn = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (a_ok && ar != 0) aq.push_back('{ar, ad});
    if (l_ok && lr != 0) lq.push_back('{lr, ld});
  endfunction

  task automatic cyc(input logic av, input logic [4:0] ar,
                     input logic [31:0] ad, input logic lv,
                     input logic [4:0] lr, input logic [31:0] ld);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
    #1 chk_all("cyc");
    @(posedge clk);
    model_edge(av, ar, ad, lv, lr, ld);
    @(negedge clk);
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; in_rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1 chk_all("reset");
    @(negedge clk);
    rst = 1'b0; in_rst = 1'b0;
    #1 chk_all("release");
    @(negedge clk);

    // Tie from reset: ALU wins first.
    cyc(1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
    chk("tie.pend0", pending, 32'h6);
    idle(1);
    chk("tie.ad3_1", 32'(ad3), 32'd1);
    chk("tie.pend1", pending, 32'h6);
    idle(1);
    chk("tie.ad3_2", 32'(ad3), 32'd2);
    chk("tie.wd3_2", wd3, 32'h22);
    chk("tie.pend2", pending, 32'h4);
    idle(1);
    chk("tie.pend3", pending, 32'h0);
    chk("tie.we3_off", 32'(we3), 32'd0);

    // Single write latency.
    cyc(1, 5'd5, 32'hAA, 0, 0, 0);
    chk("single.pend", pending, 32'h20);
    chk("single.we3_k", 32'(we3), 32'd0);
    idle(1);
    chk("single.we3", 32'(we3), 32'd1);
    chk("single.wd3", wd3, 32'hAA);
    idle(1);
    chk("single.clear", pending, 32'h0);

    // x0 write dropped.
    cyc(1, 5'd0, 32'hDEAD, 0, 0, 0);
    chk("x0.busy", 32'(busy), 32'd0);
    idle(3);

    // ALU floods while LSU holds for 3 cycles.
    for (int i = 0; i < 8; i++)
      cyc(1, 5'(1 + i), 32'h100 + i, i < 3, 5'(10 + i), 32'h200 + i);
    idle(6);

    // Both full with a write in flight, then reset mid-operation.
    for (int i = 0; i < 5; i++)
      cyc(1, 5'(3 + i), 32'h300 + i, 1, 5'(20 + i), 32'h400 + i);
    chk("prerst.we3", 32'(we3), 32'd1);
    rst = 1'b1; in_rst = 1'b1;
    model_reset();
    #1 chk_all("midrst");
    @(posedge clk);
    @(negedge clk);
    #1 chk_all("midrst_hold");
    rst = 1'b0; in_rst = 1'b0;
    #1 chk_all("midrst_rel");
    @(negedge clk);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
          $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom);
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DEPTH, 2, entries per requester queue (power of two, >=2).
REQ-002 Parameter DATA_W, 32, write-data width.
REQ-003 Ports, one per line: name  direction  width  meaning.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 alu_valid  in  1  ALU writeback request.
REQ-007 alu_ready  out  1  ALU queue can accept.
REQ-008 alu_rd  in  5  ALU destination register.
REQ-009 alu_data  in  DATA_W  ALU result.
REQ-010 lsu_valid  in  1  load writeback request.
REQ-011 lsu_ready  out  1  LSU queue can accept.
REQ-012 lsu_rd  in  5  LSU destination register.
REQ-013 lsu_data  in  DATA_W  load data.
REQ-014 we3  out  1  register-file write enable (registered).
REQ-015 ad3  out  5  register-file write address (registered).
REQ-016 wd3  out  DATA_W  register-file write data (registered).
REQ-017 pending  out  32  bit i set while any accepted, unwritten write targets x_i.
REQ-018 busy  out  1  any queue entry or output stage valid.

Function
REQ-019 Transfer on a requester occurs at a rising edge where valid=1 and ready=1; the block SHALL push {rd,data} into that requester's FIFO.
REQ-020 ready SHALL equal "FIFO not full" from registered state only, never from valid or from same-cycle pop.
REQ-021 Transfers with rd=0 SHALL be accepted (ready rules unchanged) and discarded: no push, no pending bit, never appear on we3.
REQ-022 Each cycle at most one FIFO head is granted and popped; grant SHALL be combinational from registered state.
REQ-023 Arbitration: one FIFO non-empty -> grant it; both non-empty -> grant the requester not granted last (round-robin); neither -> no grant.
REQ-024 last_grant SHALL update only on a grant.
REQ-025 On a grant at edge k the output stage SHALL load we3=1, ad3/wd3 from the head; with no grant it SHALL load we3=0 and hold ad3/wd3.
REQ-026 Latency: entry pushed at edge k SHALL, with no contention, drive we3=1 in the cycle after edge k+1 (written to the register file at edge k+2).
REQ-027 Per-requester order SHALL be preserved; cross-requester order is not guaranteed.
REQ-028 Sustained throughput SHALL be one write per cycle when any queue is non-empty.
REQ-029 pending SHALL be the OR of one-hot(rd) over all valid FIFO entries plus the output stage when we3=1, combinational from registered state.
REQ-030 Simultaneous push and pop on the same FIFO SHALL both take effect; occupancy unchanged.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter DEPTH+1 states.

Reset
REQ-032 While rst=1: FIFOs empty, pointers 0, last_grant=LSU (ALU wins first tie), we3=0, ad3=0, wd3=0, alu_ready=lsu_ready=0, pending=0, busy=0.
REQ-033 Assertion of rst mid-operation SHALL discard all queued and in-flight writes immediately; no we3 pulse after assertion.
REQ-034 First cycle after rst deasserts: alu_ready=lsu_ready=1.

Verification
REQ-035 Single ALU write x5=0x0000_00AA at edge k -> pending[5]=1 from k; we3=1, ad3=5, wd3=0xAA cycle after k+1; pending[5]=0 after k+2.
REQ-036 Both valid same edge, ALU x1=0x11, LSU x2=0x22, from reset -> writes x1 then x2 on consecutive cycles; pending=0x6 then 0x4 then 0.
REQ-037 LSU valid held 3 cycles while ALU floods with DEPTH=2 -> lsu_ready drops only when LSU FIFO holds 2; grants alternate ALU/LSU, no entry lost or reordered within requester.
REQ-038 ALU write rd=0 data 0xDEAD -> accepted, pending stays 0, we3 never asserted, busy stays 0.
REQ-039 rst asserted with both FIFOs full and we3=1 -> same cycle we3=0, pending=0, readies=0; after release readies=1, no stale writes.
REQ-040 Full FIFO with simultaneous pop -> ready stays 0 that cycle, next cycle ready=1, occupancy check matches model.
